// File: rtl/data_lsu_ctrl.sv
// Data load/store unit controller: it handles misaligned RISC-V byte/half/word accesses
// to a 32-bit word memory, splitting an access into two memory cycles when it crosses a word boundary.
module data_lsu_ctrl #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [2:0]            mem_op_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic                  r_err;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_w0;
  logic [31:0]           r_w1;

  logic                  w_accept;
  logic                  w_reqLegal;
  logic [1:0]            w_offset;
  logic [2:0]            w_size;
  logic [3:0]            w_base;
  logic                  w_split;
  logic [7:0]            w_mask8;
  logic [63:0]           w_wshift;
  logic [31:0]           w_rshift;
  logic [31:0]           w_loadData;
  logic [ADDR_WIDTH-1:0] w_wordAddr;
  logic [ADDR_WIDTH-1:0] w_wordNext;

  assign w_accept    = req_valid && (r_state == IDLE);
  assign mem_op_read = 3'b010;

  always_comb begin
    w_reqLegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_reqLegal = 1'b1;
      3'b100, 3'b101:         w_reqLegal = !req_we;
      default:                w_reqLegal = 1'b0;
    endcase
  end

  assign w_offset = r_addr[1:0];

  always_comb begin
    w_size = 3'd4;
    w_base = 4'b1111;
    case (r_funct3[1:0])
      2'b00: begin w_size = 3'd1; w_base = 4'b0001; end
      2'b01: begin w_size = 3'd2; w_base = 4'b0011; end
      default: begin w_size = 3'd4; w_base = 4'b1111; end
    endcase
  end

  // The two-word window {W1,W0} carries a misaligned access that spills into the next word.
  assign w_split    = ({1'b0, w_offset} + w_size) > 3'd4;
  assign w_mask8    = {4'b0000, w_base} << w_offset;
  assign w_wshift   = {32'h0, r_wdata} << {w_offset, 3'b000};
  assign w_rshift   = 32'({r_w1, r_w0} >> {w_offset, 3'b000});
  assign w_wordAddr = r_addr[ADDR_WIDTH+1:2];
  assign w_wordNext = w_wordAddr + ADDR_WIDTH'(1);

  always_comb begin
    w_loadData = w_rshift;
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_rshift[7]}}, w_rshift[7:0]};
      3'b001:  w_loadData = {{16{w_rshift[15]}}, w_rshift[15:0]};
      3'b100:  w_loadData = {24'h0, w_rshift[7:0]};
      3'b101:  w_loadData = {16'h0, w_rshift[15:0]};
      default: w_loadData = w_rshift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_w0     <= 32'h0;
      r_w1     <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_err    <= !w_reqLegal;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_w0     <= 32'h0;
        r_w1     <= 32'h0;
      end
      if (r_state == ACC0) r_w0 <= mem_rdata;
      if (r_state == ACC1) r_w1 <= mem_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_reqLegal ? ACC0 : RESP;
      ACC0:    w_next = w_split ? ACC1 : RESP;
      ACC1:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are gated by rst_n so that a reset landing in ACC1 blocks the second write.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    case (r_state)
      IDLE: req_ready = rst_n;
      ACC0: begin
        mem_addr = w_wordAddr;
        if (r_we) begin
          mem_we    = rst_n;
          mem_be    = rst_n ? w_mask8[3:0] : 4'b0000;
          mem_wdata = w_wshift[31:0];
        end
      end
      ACC1: begin
        mem_addr = w_wordNext;
        if (r_we) begin
          mem_we    = rst_n;
          mem_be    = rst_n ? w_mask8[7:4] : 4'b0000;
          mem_wdata = w_wshift[63:32];
        end
      end
      RESP: begin
        resp_valid = rst_n;
        resp_err   = rst_n && r_err;
        if (rst_n && !r_we && !r_err) resp_rdata = w_loadData;
      end
      default: ;
    endcase
  end

endmodule
